// File: rtl/collide_pkg.sv
// Shared definitions for the collision scheduler: FSM encoding and default sizes.
package collide_pkg;

    localparam int GRID_W_DEF = 8192;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/collide_hit_reduce.sv
// Combinational collision test: any grid cell both reached and occupied.
module collide_hit_reduce
    import collide_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF
) (
    input  logic [GRID_W-1:0] edge_state,
    input  logic [GRID_W-1:0] obstacle_map,
    output logic              hit
);

    assign hit = |(edge_state & obstacle_map);

endmodule

// File: rtl/collide_sched.sv
// Collision query scheduler: streams grid reads into an external OR accumulator,
// then tests the accumulated footprint against the obstacle map.
module collide_sched
    import collide_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [CNT_W-1:0]  gridCnt,
    input  logic [GRID_W-1:0] obstacleMap,
    output logic [ADDR_W-1:0] gridAddr,
    output logic              gridRdEn,
    input  logic [GRID_W-1:0] memData,
    output logic              collideClear,
    output logic [GRID_W-1:0] oneGridState,
    input  logic [GRID_W-1:0] edgeState,
    output logic              busy,
    output logic              done,
    output logic              hit
);

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   rem_r;
    logic               rd_valid_r;
    logic               hit_r;
    logic               hit_s;
    logic               accept_s;
    logic               rd_en_s;

    collide_hit_reduce #(
        .GRID_W (GRID_W)
    ) u_hit_reduce (
        .edge_state   (edgeState),
        .obstacle_map (obstacleMap),
        .hit          (hit_s)
    );

    // Next-state logic; abort pre-empts every busy state.
    always_comb begin
        state_s = state_r;
        if ((state_r != ST_IDLE) && abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_s = ST_CLEAR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_s = ST_READ;
                    end else begin
                        state_s = ST_CHECK;
                    end
                end
                ST_READ: begin
                    if (rem_r == CNT_W'(1)) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_READ;
                    end
                end
                ST_DRAIN: state_s = ST_CHECK;
                ST_CHECK: state_s = ST_DONE;
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode; abort acts in the same cycle it is seen.
    always_comb begin
        accept_s     = 1'b0;
        busy         = 1'b0;
        rd_en_s      = 1'b0;
        collideClear = 1'b0;
        done         = 1'b0;
        accept_s     = (state_r == ST_IDLE) && start && !abort;
        busy         = (state_r != ST_IDLE);
        rd_en_s      = (state_r == ST_READ) && !abort;
        collideClear = (state_r == ST_CLEAR) || (busy && abort);
        done         = (state_r == ST_DONE) && !abort;
    end

    assign gridRdEn     = rd_en_s;
    assign gridAddr     = addr_r;
    assign hit          = hit_r;
    assign oneGridState = rd_valid_r ? memData : {GRID_W{1'b0}};

    // State, command latch, read address walk and hit capture.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r    <= ST_IDLE;
            base_r     <= {ADDR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            rem_r      <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
            hit_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            rd_valid_r <= rd_en_s;
            if (accept_s) begin
                base_r <= baseAddr;
                cnt_r  <= gridCnt;
                hit_r  <= 1'b0;
            end
            // gridAddr only moves on entry to and within READ, so it holds the last address otherwise.
            if ((state_r == ST_CLEAR) && (state_s == ST_READ)) begin
                addr_r <= base_r;
                rem_r  <= cnt_r;
            end else if ((state_r == ST_READ) && (state_s == ST_READ)) begin
                addr_r <= addr_r + ADDR_W'(1);
                rem_r  <= rem_r - CNT_W'(1);
            end
            if ((state_r == ST_CHECK) && !abort) begin
                hit_r <= hit_s;
            end
        end
    end

endmodule

// File: doc/collide_sched.md
COLLIDE_SCHED -- requirements
Module: collide_sched

Interface
REQ-001 Parameters SHALL be: GRID_W, default 8192, grid state width; ADDR_W, default 10, grid memory address width; CNT_W, default 11, grid count width.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  query request; sampled only in IDLE.
REQ-005 abort  input  1  cancel the running query.
REQ-006 baseAddr  input  ADDR_W  first grid memory address of the query.
REQ-007 gridCnt  input  CNT_W  number of grids to accumulate; 0 is legal.
REQ-008 obstacleMap  input  GRID_W  obstacle occupancy, stable while busy.
REQ-009 gridAddr  output  ADDR_W  grid memory read address.
REQ-010 gridRdEn  output  1  grid memory read enable; data returns exactly 1 cycle later.
REQ-011 memData  input  GRID_W  grid memory read data.
REQ-012 collideClear  output  1  clear strobe to the accumulator.
REQ-013 oneGridState  output  GRID_W  accumulator operand.
REQ-014 edgeState  input  GRID_W  accumulator result (registered OR of all operands since the last clear).
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 hit  output  1  collision result; valid when done is high and held until the next accepted start.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, READ, DRAIN, CHECK and DONE.
REQ-019 IDLE with start=1 SHALL latch baseAddr and gridCnt, clear hit, and go to CLEAR.
REQ-020 CLEAR SHALL assert collideClear for exactly one cycle, then go to READ if gridCnt>0, else to CHECK.
REQ-021 READ SHALL assert gridRdEn with gridAddr=baseAddr+i for i=0..gridCnt-1, one per cycle, with the address wrapping modulo 2^ADDR_W, then go to DRAIN.
REQ-022 DRAIN SHALL last one cycle, then go to CHECK.
REQ-023 A 1-cycle delayed copy of gridRdEn (rdValid) SHALL gate the operand: oneGridState=memData when rdValid=1, else all zeros.
REQ-024 CHECK SHALL register hit = OR-reduction of (edgeState AND obstacleMap), then go to DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 Latency SHALL be: start sampled at edge 0; done high in cycle gridCnt+4 for gridCnt>0, and in cycle 3 for gridCnt=0.
REQ-027 start while busy SHALL be ignored and not queued.
REQ-028 abort in any non-IDLE state SHALL force the next state to IDLE, assert collideClear for that cycle, deassert gridRdEn, suppress done, and leave hit at 0.
REQ-029 abort and start in the same IDLE cycle: abort SHALL win, and the start SHALL be dropped.
REQ-030 When not in READ, gridAddr SHALL hold its last value and gridRdEn SHALL be 0.

Reset
REQ-031 While RST_n=0: state=IDLE, busy=0, done=0, hit=0, gridRdEn=0, rdValid=0, gridAddr=0, collideClear=0, and all latched command registers 0.
REQ-032 Reset asserted mid-query SHALL discard the query with no done pulse; the first start after release SHALL behave as a fresh query.

Structure
REQ-033 The FSM state encoding and the GRID_W/ADDR_W/CNT_W defaults SHALL reside in shared package collide_pkg.
REQ-034 The hit reduction SHALL be a sub-module collide_hit_reduce (combinational AND/OR tree), instantiated once; everything else stays flat.

Verification
REQ-035 Reset mid-READ (gridCnt=5, after 2 reads) -> all outputs at reset values immediately; no done; a following start with gridCnt=1 completes in 5 cycles.
REQ-036 baseAddr=3, gridCnt=3, memData(addr)=1<<addr, obstacleMap=1<<4 -> addresses 3,4,5; one collideClear; edgeState=0x38; hit=1; done in cycle 7.
REQ-037 Same query with obstacleMap=1<<6 -> hit=0; done in cycle 7.
REQ-038 gridCnt=0 -> no gridRdEn; done in cycle 3; hit=0.
REQ-039 baseAddr=1022, gridCnt=4 -> addresses 1022,1023,0,1; start pulsed during READ is ignored (busy stays 1; done pulses exactly once).
REQ-040 abort in cycle 3 of a gridCnt=8 query -> IDLE next cycle, collideClear=1 that cycle, gridRdEn=0, no done, hit=0.
